// File: rtl/bin2seg_seq.sv
// Sequential binary-to-BCD (double dabble, one bit per clock) with registered
// active-low seven-segment outputs. Define BIN2SEG_LZB_EN for leading-zero blanking.
module bin2seg_seq #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   segs,
  output logic [1:0]            dbg_state_o
);

  // Handshake: start is sampled only while idle (busy=0); busy rises the cycle
  // after an accepted start and drops together with the single-cycle done pulse.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd2} state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT        = pow10(DIGITS);
  localparam logic [64:0] SPAN         = 65'd1 << IN_WIDTH;
  localparam bit          OVF_POSSIBLE = (SPAN > {1'b0, LIMIT});
  localparam int          CW           = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(IN_WIDTH);

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  state_t                state_q;
  logic [IN_WIDTH-1:0]   op_q;
  logic [4*DIGITS-1:0]   scratch_q;
  logic [CW-1:0]         cnt_q;
  logic                  ovf_pend_q;
  logic [4*DIGITS-1:0]   adj_d;
  logic [4*DIGITS-1:0]   shift_d;
  logic [7*DIGITS-1:0]   segs_d;
  logic                  ovf_now;

  // Values that do not fit in DIGITS digits are flagged at capture time.
  assign ovf_now = OVF_POSSIBLE &&
                   ({{(64-IN_WIDTH){1'b0}}, value} >= LIMIT);

  always_comb begin
    adj_d = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
    shift_d = {adj_d[4*DIGITS-2:0], op_q[IN_WIDTH-1]};
  end

`ifdef BIN2SEG_LZB_EN
  logic lead;
  always_comb begin
    segs_d = '0;
    lead   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      segs_d[7*i +: 7] = seg7(scratch_q[4*i +: 4]);
      // Digit 0 is never blanked so a zero value still shows "0".
      if (lead && (scratch_q[4*i +: 4] == 4'd0) && (i != 0))
        segs_d[7*i +: 7] = 7'b1111111;
      else
        lead = 1'b0;
    end
  end
`else
  always_comb begin
    segs_d = '0;
    for (int i = 0; i < DIGITS; i++) segs_d[7*i +: 7] = seg7(scratch_q[4*i +: 4]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      bcd        <= '0;
      segs       <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q       <= value;
            scratch_q  <= '0;
            cnt_q      <= CNT_INIT;
            ovf_pend_q <= ovf_now;
            busy       <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= shift_d;
          op_q      <= op_q << 1;
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= LOAD;
        end
        LOAD: begin
          overflow <= ovf_pend_q;
          if (ovf_pend_q) begin
            bcd  <= '1;
            segs <= {DIGITS{7'b0111111}};
          end else begin
            bcd  <= scratch_q;
            segs <= segs_d;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bin2seg_seq.sv
// Bench for bin2seg_seq: a 3-digit and a 2-digit instance, directed sequences,
// a vector table and randomized conversions checked against an arithmetic model.
module tb_bin2seg_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start_a, busy_a, done_a, ovf_a;
  logic [7:0]  value_a;
  logic [11:0] bcd_a;
  logic [20:0] segs_a;
  logic [1:0]  st_a;

  logic        start_b, busy_b, done_b, ovf_b;
  logic [7:0]  value_b;
  logic [7:0]  bcd_b;
  logic [13:0] segs_b;
  logic [1:0]  st_b;

  bin2seg_seq #(.IN_WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .value(value_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .bcd(bcd_a),
    .segs(segs_a), .dbg_state_o(st_a));

  bin2seg_seq #(.IN_WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .value(value_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .bcd(bcd_b),
    .segs(segs_b), .dbg_state_o(st_b));

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  typedef struct {
    int          sel;
    int unsigned v;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? ovf_a : ovf_b;
  endfunction
  function automatic logic [11:0] get_bcd(input int sel);
    return (sel == 0) ? bcd_a : {4'h0, bcd_b};
  endfunction
  function automatic logic [20:0] get_segs(input int sel);
    return (sel == 0) ? segs_a : {7'h00, segs_b};
  endfunction
  function automatic logic [33:0] observed(input int sel);
    return {get_ovf(sel), get_segs(sel), get_bcd(sel)};
  endfunction

  // Reference: decimal digits by division, display rules applied per digit.
  function automatic logic [33:0] ref_exp(input int unsigned v, input int nd);
    longint unsigned p, lim;
    logic [11:0] b;
    logic [20:0] s;
    logic        o;
    int          d;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    o = (longint'(v) >= lim);
    b = '0;
    s = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      if (o) begin
        b[4*i +: 4] = 4'hF;
        s[7*i +: 7] = 7'b0111111;
      end else begin
        d = int'((longint'(v) / p) % 10);
        b[4*i +: 4] = 4'(d);
        s[7*i +: 7] = seg_tab[d];
`ifdef BIN2SEG_LZB_EN
        if (i > 0 && longint'(v) < p) s[7*i +: 7] = 7'b1111111;
`endif
      end
      p = p * 10;
    end
    return {o, s, b};
  endfunction

  task automatic launch(input int sel, input int unsigned v);
    exp_q.push_back(ref_exp(v, (sel == 0) ? 3 : 2));
    if (sel == 0) begin start_a = 1'b1; value_a = v[7:0]; end
    else          begin start_b = 1'b1; value_b = v[7:0]; end
    @(posedge clk);
    @(negedge clk);
    if (sel == 0) begin start_a = 1'b0; value_a = 8'($urandom); end
    else          begin start_b = 1'b0; value_b = 8'($urandom); end
  endtask

  // Called at the falling edge after the start edge; returns the cycle index of done.
  task automatic wait_done(input int sel, input bit spam, output int k, output int busy_n);
    logic [11:0] prev;
    bit changed;
    logic [33:0] e;
    prev = get_bcd(sel);
    changed = 0;
    k = 1;
    busy_n = 0;
    while (!get_done(sel) && k < 40) begin
      if (get_busy(sel)) busy_n++;
      if (get_bcd(sel) !== prev) changed = 1;
      @(negedge clk);
      k++;
      if (spam) begin
        if (k >= 2 && k <= 5) begin start_a = 1'b1; value_a = 8'd200; end
        else start_a = 1'b0;
      end
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!get_done(sel)) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", k);
    end else begin
      check("result", observed(sel), e);
      check("busy_at_done", 34'(get_busy(sel)), 34'd0);
      check("hold_until_load", 34'(changed), 34'd0);
    end
  endtask

  task automatic conv(input int sel, input int unsigned v);
    int k, b;
    launch(sel, v);
    wait_done(sel, 1'b0, k, b);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_a) cnt++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[12];
    int k, b, nd;
    int unsigned v;
    int sel;

    vecs = '{
      '{0, 1,   12'h001, 1'b0}, '{0, 7,   12'h007, 1'b0},
      '{0, 9,   12'h009, 1'b0}, '{0, 99,  12'h099, 1'b0},
      '{0, 100, 12'h100, 1'b0}, '{0, 128, 12'h128, 1'b0},
      '{0, 200, 12'h200, 1'b0}, '{0, 254, 12'h254, 1'b0},
      '{1, 0,   12'h000, 1'b0}, '{1, 42,  12'h042, 1'b0},
      '{1, 100, 12'h0FF, 1'b1}, '{1, 255, 12'h0FF, 1'b1}};

    // clock/reset
    rst_n = 1'b0;
    start_a = 1'b0; value_a = '0;
    start_b = 1'b0; value_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 34'(busy_a), 34'd0);
    check("reset_done", 34'(done_a), 34'd0);
    check("reset_ovf", 34'(ovf_a), 34'd0);
    check("reset_bcd", 34'(bcd_a), 34'd0);
    check("reset_segs", 34'(segs_a), 34'h1FFFFF);
    check("reset_segs_b", 34'(segs_b), 34'h3FFF);
    check("reset_state", 34'(st_a), 34'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // value 0: latency and zero display
    launch(0, 0);
    wait_done(0, 1'b0, k, b);
    check("latency_zero", 34'(k), 34'd10);
    check("bcd_zero", 34'(bcd_a), 34'h000);
`ifdef BIN2SEG_LZB_EN
    check("segs_zero", 34'(segs_a), 34'({7'b1111111, 7'b1111111, 7'b1000000}));
`else
    check("segs_zero", 34'(segs_a), 34'({7'b1000000, 7'b1000000, 7'b1000000}));
`endif

    // value 255: busy duration and full display
    launch(0, 255);
    wait_done(0, 1'b0, k, b);
    check("busy_cycles", 34'(b), 34'd9);
    check("bcd_255", 34'(bcd_a), 34'h255);
    check("segs_255", 34'(segs_a), 34'({7'b0100100, 7'b0010010, 7'b0010010}));

    // back-to-back: second start issued in the done cycle
    launch(0, 10);
    wait_done(0, 1'b0, k, b);
    check("bcd_010", 34'(bcd_a), 34'h010);
    launch(0, 9);
    wait_done(0, 1'b0, k, b);
    check("done_spacing", 34'(k), 34'd10);
    check("bcd_009", 34'(bcd_a), 34'h009);

    // 2-digit overflow boundary
    conv(1, 100);
    check("ovf_100", 34'(ovf_b), 34'd1);
    check("bcd_ovf", 34'(bcd_b), 34'hFF);
    check("segs_dash", 34'(segs_b), 34'({7'b0111111, 7'b0111111}));
    conv(1, 99);
    check("ovf_99", 34'(ovf_b), 34'd0);
    check("bcd_99", 34'(bcd_b), 34'h99);

    // start while busy is ignored
    launch(0, 37);
    wait_done(0, 1'b1, k, b);
    check("bcd_037", 34'(bcd_a), 34'h037);
    count_dones(15, k);
    check("single_done", 34'(k), 34'd0);

    // vector table
    for (int i = 0; i < 12; i++) begin
      conv(vecs[i].sel, vecs[i].v);
      check("table_bcd", 34'(get_bcd(vecs[i].sel)), 34'(vecs[i].bcd));
      check("table_ovf", 34'(get_ovf(vecs[i].sel)), 34'(vecs[i].ovf));
    end

    // reset mid-conversion
    launch(0, 128);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 34'(busy_a), 34'd0);
    check("abort_done", 34'(done_a), 34'd0);
    check("abort_bcd", 34'(bcd_a), 34'h000);
    check("abort_segs", 34'(segs_a), 34'h1FFFFF);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(15, k);
    check("abort_no_done", 34'(k), 34'd0);
    conv(0, 64);
    check("bcd_064", 34'(bcd_a), 34'h064);

    // randomized conversions against the model
    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 1));
      v   = $urandom_range(0, 255);
      nd  = (sel == 0) ? 3 : 2;
      conv(sel, v);
      if (nd == 2 && v >= 100) check("rand_ovf", 34'(get_ovf(sel)), 34'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check("queue_empty", 34'(exp_q.size()), 34'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
